// File: rtl/axis_pkt_arbiter.sv
// Packet-level 2:1 arbiter for an AXI-Stream switch: weighted round-robin with grant lock until tlast.
// Optional macro ARB_SUPPRESS_EN adds the s_req_supress_i per-port request mask.
module axis_pkt_arbiter #(
    parameter int unsigned W0 = 1,
    parameter int unsigned W1 = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
`ifdef ARB_SUPPRESS_EN
    input  logic [1:0] s_req_supress_i,
`endif
    input  logic       beat_i,
    input  logic       last_i,
    output logic [1:0] grant_o,
    output logic       busy_o
);

    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [3:0] W0_L = W0[3:0];
    localparam logic [3:0] W1_L = W1[3:0];

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       ptr_q, ptr_d;
    logic       prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic       armed_q;

    logic [1:0] mask;
    logic [1:0] eff;
    logic       cur;
    logic       win;
    logic [3:0] cnt_inc;
    logic [3:0] wcur;

`ifdef ARB_SUPPRESS_EN
    assign mask = s_req_supress_i;
`else
    assign mask = 2'b00;
`endif
    assign eff = req_i & ~mask;

    // Both requesting: pointer decides; a single requester always wins.
    function automatic logic pick(input logic [1:0] e, input logic p);
        if (e == 2'b11) return p;
        return e[1];
    endfunction

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        win     = 1'b0;
        cur     = grant_q[1];
        cnt_inc = cnt_q + 4'd1;
        wcur    = cur ? W1_L : W0_L;
        case (state_q)
            IDLE: begin
                if (armed_q && (eff != 2'b00)) begin
                    win     = pick(eff, ptr_q);
                    grant_d = win ? 2'b10 : 2'b01;
                    state_d = LOCK;
                    prev_d  = win;
                    if (win != prev_q) cnt_d = '0;
                end
            end
            LOCK: begin
                if (beat_i && last_i) begin
                    if (cnt_inc == wcur) begin
                        ptr_d = ~cur;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                    // Re-arbitrate against the updated pointer for a zero-bubble handoff.
                    if (eff == 2'b00) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        win     = pick(eff, ptr_d);
                        grant_d = win ? 2'b10 : 2'b01;
                        prev_d  = win;
                        if (win != cur) cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = |grant_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: two instances (W0=W1=1 and W0=3,W1=1) on shared stimulus.
module tb_axis_pkt_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] sup;
    logic       beat;
    logic       last;
    logic [1:0] grant_a, grant_b;
    logic       busy_a, busy_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.W0(1), .W1(1)) dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req),
`ifdef ARB_SUPPRESS_EN
        .s_req_supress_i (sup),
`endif
        .beat_i          (beat),
        .last_i          (last),
        .grant_o         (grant_a),
        .busy_o          (busy_a)
    );

    axis_pkt_arbiter #(.W0(3), .W1(1)) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req),
`ifdef ARB_SUPPRESS_EN
        .s_req_supress_i (sup),
`endif
        .beat_i          (beat),
        .last_i          (last),
        .grant_o         (grant_b),
        .busy_o          (busy_b)
    );

    // Compares {busy, grant} against the expected 3-bit value.
    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUTs armed (first post-reset edge taken) with idle inputs.
    task automatic do_reset();
        req   = 2'b00;
        beat  = 1'b0;
        last  = 1'b0;
        sup   = 2'b00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [1:0] exp_a [8];
    logic [1:0] exp_b [8];

    initial begin
        exp_a = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        exp_b = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

        rst_n = 1'b0; req = 2'b00; sup = 2'b00; beat = 1'b0; last = 1'b0;
        tick();
        tick();
        check("reset_a", {busy_a, grant_a}, 3'b000);
        check("reset_b", {busy_b, grant_b}, 3'b000);

        // Release with port 0 requesting: grant only at the second edge.
        rst_n = 1'b1;
        req   = 2'b01;
        tick();
        check("post_rst_edge1", {busy_a, grant_a}, 3'b000);
        tick();
        check("post_rst_edge2", {busy_a, grant_a}, 3'b101);
        req  = 2'b00;
        beat = 1'b1;
        last = 1'b1;
        tick();
        check("single_last_release", {busy_a, grant_a}, 3'b000);
        tick();
        check("beat_in_idle_ignored", {busy_a, grant_a}, 3'b000);

        // Both requesting, single-beat packets every cycle.
        do_reset();
        req  = 2'b11;
        beat = 1'b1;
        last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr_w1_%0d", i), {busy_a, grant_a}, {1'b1, exp_a[i]});
            check($sformatf("rr_w3_%0d", i), {busy_b, grant_b}, {1'b1, exp_b[i]});
        end

        // Work-conserving: only port 0 requests, it keeps being re-granted.
        do_reset();
        req  = 2'b01;
        beat = 1'b1;
        last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("wc_a_%0d", i), {busy_a, grant_a}, 3'b101);
            check($sformatf("wc_b_%0d", i), {busy_b, grant_b}, 3'b101);
        end
        // Port 0 has just used its turn on A; port 1 must now win the tie.
        req = 2'b11;
        tick();
        check("wc_handoff_a", {busy_a, grant_a}, 3'b110);

        // Port 1, 3-beat packet, requests drop after beat 1.
        do_reset();
        req = 2'b10;
        tick();
        check("p1_grant", {busy_a, grant_a}, 3'b110);
        beat = 1'b1;
        last = 1'b0;
        tick();
        check("p1_beat1", {busy_a, grant_a}, 3'b110);
        req = 2'b00;
        tick();
        check("p1_beat2_req_dropped", {busy_a, grant_a}, 3'b110);
        beat = 1'b0;
        tick();
        check("p1_no_beat_hold", {busy_a, grant_a}, 3'b110);
        beat = 1'b1;
        last = 1'b1;
        tick();
        check("p1_last_to_idle", {busy_a, grant_a}, 3'b000);

`ifdef ARB_SUPPRESS_EN
        do_reset();
        sup  = 2'b01;
        req  = 2'b11;
        tick();
        check("sup_only_p1", {busy_a, grant_a}, 3'b110);
        beat = 1'b1;
        last = 1'b0;
        sup  = 2'b10;
        tick();
        check("sup_change_hold", {busy_a, grant_a}, 3'b110);
        last = 1'b1;
        tick();
        check("sup_after_last", {busy_a, grant_a}, 3'b101);
`endif

        // Reset pulsed during beat 2 of a 4-beat port-1 packet.
        do_reset();
        req = 2'b10;
        tick();
        check("rst_mid_grant", {busy_a, grant_a}, 3'b110);
        beat = 1'b1;
        last = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", {busy_a, grant_a}, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        req   = 2'b11;
        beat  = 1'b0;
        tick();
        check("rst_mid_edge1", {busy_a, grant_a}, 3'b000);
        tick();
        check("rst_mid_regrant", {busy_a, grant_a}, 3'b101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
